fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the CPU front end.
// The master modport is the fetch unit side; the slave modport is the memory/CPU environment.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetch unit: IDLE/FETCH/SQUASH request FSM feeding a DEPTH-entry FIFO of {pc, instr}.
// Define FETCH_PERF_EN to add the fetch_count output counting accepted (non-discarded) fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef FETCH_PERF_EN
    output logic [31:0]  fetch_count,
`endif
    fetch_unit_if.master bus
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic          r_memReq;
    logic          w_memReqNext;
    logic [31:0]   r_memAddr;
    logic [31:0]   w_memAddrNext;
    logic [31:0]   r_nextPc;
    logic [31:0]   w_nextPcNext;

    logic [31:0]   r_pcBuf    [DEPTH];
    logic [31:0]   r_instrBuf [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_valid;
    logic [CW-1:0] w_countAfterPush;
    logic [31:0]   w_redirectPc;
    logic [31:0]   w_addrPlus4;

    assign w_valid          = (r_count != '0);
    assign w_pop            = w_valid && bus.instr_ready && !bus.redirect;
    assign w_countAfterPush = r_count + CW'(1) - CW'(w_pop);
    assign w_redirectPc     = {bus.redirect_pc[31:2], 2'b00};
    assign w_addrPlus4      = r_memAddr + 32'd4;

    // Request FSM: a redirect always wins; an outstanding request is never retracted,
    // so a redirect without ack parks in SQUASH until the stale response arrives.
    always_comb begin
        w_stateNext   = r_state;
        w_memReqNext  = r_memReq;
        w_memAddrNext = r_memAddr;
        w_nextPcNext  = r_nextPc;
        w_push        = 1'b0;
        w_flush       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.redirect) begin
                    w_flush       = 1'b1;
                    w_stateNext   = FETCH;
                    w_memReqNext  = 1'b1;
                    w_memAddrNext = w_redirectPc;
                    w_nextPcNext  = w_redirectPc;
                end else if (r_count < FULL) begin
                    w_stateNext   = FETCH;
                    w_memReqNext  = 1'b1;
                    w_memAddrNext = r_nextPc;
                end
            end

            FETCH: begin
                if (bus.redirect) begin
                    w_flush      = 1'b1;
                    w_nextPcNext = w_redirectPc;
                    if (bus.mem_ack) begin
                        w_memAddrNext = w_redirectPc;
                    end else begin
                        w_stateNext = SQUASH;
                    end
                end else if (bus.mem_ack) begin
                    w_push       = 1'b1;
                    w_nextPcNext = w_addrPlus4;
                    if (w_countAfterPush < FULL) begin
                        w_memAddrNext = w_addrPlus4;
                    end else begin
                        w_stateNext  = IDLE;
                        w_memReqNext = 1'b0;
                    end
                end
            end

            SQUASH: begin
                if (bus.redirect) begin
                    w_flush      = 1'b1;
                    w_nextPcNext = w_redirectPc;
                    if (bus.mem_ack) begin
                        w_stateNext   = FETCH;
                        w_memAddrNext = w_redirectPc;
                    end
                end else if (bus.mem_ack) begin
                    w_stateNext   = FETCH;
                    w_memAddrNext = r_nextPc;
                end
            end

            default: begin
                w_stateNext  = IDLE;
                w_memReqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_memReq  <= 1'b0;
            r_memAddr <= RESET_PC;
            r_nextPc  <= RESET_PC;
        end else begin
            r_state   <= w_stateNext;
            r_memReq  <= w_memReqNext;
            r_memAddr <= w_memAddrNext;
            r_nextPc  <= w_nextPcNext;
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_pcBuf[r_tail]    <= r_memAddr;
            r_instrBuf[r_tail] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req     = r_memReq;
    assign bus.mem_addr    = r_memAddr;
    assign bus.instr_valid = w_valid;
    assign bus.instr_out   = w_valid ? r_instrBuf[r_head] : 32'h0;
    assign bus.instr_pc    = w_valid ? r_pcBuf[r_head] : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetchCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchCount <= 32'h0;
        end else if (w_push && !w_flush) begin
            r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

    assign fetch_count = r_fetchCount;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model queues expected {pc, instr} on every accepted ack
// and compares the head each cycle; a second instance checks PC wrap from RESET_PC 32'hFFFF_FFF8.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if wrapBus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] wrapFetchCount;
`endif

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FETCH_PERF_EN
        .fetch_count(fetchCount),
`endif
        .bus        (bus)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8),
        .DEPTH   (4)
    ) wrapDut (
        .clk        (clk),
        .rst        (rst),
`ifdef FETCH_PERF_EN
        .fetch_count(wrapFetchCount),
`endif
        .bus        (wrapBus)
    );

    // The wrap instance sees a memory that acks every request and a CPU that always pops.
    assign wrapBus.mem_ack     = wrapBus.mem_req;
    assign wrapBus.mem_rdata   = ~wrapBus.mem_addr;
    assign wrapBus.instr_ready = 1'b1;
    assign wrapBus.redirect    = 1'b0;
    assign wrapBus.redirect_pc = 32'h0;

    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [63:0] sb [$];
    logic [31:0] modelAddr;
    bit          modelReq;
    bit          stale;
    logic [31:0] accepted;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkHead();
        checkOutput("memReq", 32'(bus.mem_req), 32'(modelReq));
        checkOutput("instrValid", 32'(bus.instr_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            checkOutput("instrPc", bus.instr_pc, sb[0][63:32]);
            checkOutput("instrOut", bus.instr_out, sb[0][31:0]);
        end
`ifdef FETCH_PERF_EN
        checkOutput("fetchCount", fetchCount, accepted);
`endif
    endtask

    // One cycle: drive inputs after a falling edge, advance the model, check after the next falling edge.
    task automatic applyStimulus(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
        int sizeBefore;
        bit accAck;
        bit nextReq;
        sizeBefore          = sb.size();
        accAck              = ack && modelReq;
        bus.mem_ack         = accAck;
        bus.mem_rdata       = accAck ? memWord(bus.mem_addr) : 32'h0;
        bus.instr_ready     = ready;
        bus.redirect        = redir;
        bus.redirect_pc     = rpc;
        nextReq             = modelReq;
        if (!modelReq) begin
            nextReq = redir || (sizeBefore < 4);
        end
        if (redir) begin
            sb.delete();
            stale     = modelReq && !accAck;
            nextReq   = 1'b1;
            modelAddr = {rpc[31:2], 2'b00};
        end else begin
            if (ready && sizeBefore > 0) begin
                void'(sb.pop_front());
            end
            if (accAck) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    checkOutput("ackAddr", bus.mem_addr, modelAddr);
                    sb.push_back({modelAddr, memWord(modelAddr)});
                    modelAddr = modelAddr + 32'd4;
                    accepted  = accepted + 32'd1;
                    nextReq   = (sb.size() < 4);
                end
            end
        end
        modelReq = nextReq;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.redirect = 1'b0;
        checkHead();
    endtask

    // Reset from any state, then offer a spurious ack in the first post-reset cycle, which must be ignored.
    task automatic doReset();
        rst             = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'h0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("rstMemReq", 32'(bus.mem_req), 32'h0);
        checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
        checkOutput("rstValid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rstInstrOut", bus.instr_out, 32'h0);
        checkOutput("rstInstrPc", bus.instr_pc, 32'h0);
        checkOutput("rstWrapAddr", wrapBus.mem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        checkOutput("rstFetchCount", fetchCount, 32'h0);
`endif
        sb.delete();
        stale         = 1'b0;
        accepted      = 32'h0;
        modelAddr     = 32'h0;
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        modelReq      = 1'b1;
        checkOutput("postRstAddr", bus.mem_addr, 32'h0);
        checkHead();
    endtask

    logic [31:0] wrapExp [3];

    initial begin
        wrapExp[0] = 32'hFFFF_FFF8;
        wrapExp[1] = 32'hFFFF_FFFC;
        wrapExp[2] = 32'h0000_0000;
        modelReq   = 1'b0;
        stale      = 1'b0;
        accepted   = 32'h0;
        modelAddr  = 32'h0;
        @(negedge clk);
        doReset();

        // Streaming with acks every cycle; the wrap instance is checked on the same cycles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (i < 3) begin
                checkOutput("wrapValid", 32'(wrapBus.instr_valid), 32'h1);
                checkOutput("wrapPc", wrapBus.instr_pc, wrapExp[i]);
                checkOutput("wrapInstr", wrapBus.instr_out, ~wrapExp[i]);
            end
        end

        // Fill the buffer with the CPU stalled, then pop once and expect fetch to resume at 0x10.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fullIdleReq", 32'(bus.mem_req), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("resumeAddr", bus.mem_addr, 32'h0000_0010);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect while a request is outstanding; the late response must be dropped.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("squashAddr", bus.mem_addr, 32'h0000_0100);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Second redirect while squashing replaces the pending target.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0404);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reSquashAddr", bus.mem_addr, 32'h0000_0404);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with ack and pop while the buffer holds entries.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        checkOutput("ackRedirAddr", bus.mem_addr, 32'h0000_0200);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect from IDLE with a full buffer.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        checkOutput("idleRedirAddr", bus.mem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 19) == 0, $urandom);
        end

        // Reset in the middle of traffic.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        doReset();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
